// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt frame loader.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM state.
package bcrypt_pkg;

   localparam logic [7:0] HDR_BYTE   = 8'hA5;
   localparam int         KEY_MAX    = 72;
   localparam int         KEY_WORDS  = 18;
   localparam int         SALT_BYTES = 16;
   localparam int         COST_MIN   = 4;
   localparam int         COST_MAX   = 31;

   typedef enum logic [3:0] {
      IDLE,
      COST,
      KLEN,
      KEY,
      SALT,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      EMIT,
      ARMED,
      ERR
   } state_e;

   // Advance a key byte index by one, wrapping to zero at the key length.
   // A compare-and-clear replaces any modulo so no divider is built.
   function automatic logic [6:0] wrapInc(input logic [6:0] idx, input logic [6:0] len);
      logic [6:0] nxt;
      nxt = idx + 7'd1;
      return (nxt == len) ? 7'd0 : nxt;
   endfunction

endpackage

// File: rtl/key_cycler.sv
// Key byte buffer plus a wrapping read pointer that hands out one
// big-endian 32-bit word of the cyclically repeated key per cycle.
module key_cycler
   import bcrypt_pkg::*;
(
   input  logic        clk,
   input  logic        rst_l,
   input  logic        wr_en_i,
   input  logic [6:0]  wr_idx_i,
   input  logic [7:0]  wr_data_i,
   input  logic [6:0]  key_len_i,
   input  logic        rd_clear_i,
   input  logic        rd_adv_i,
   output logic [31:0] word_o
);

   logic [7:0] keyBuf_q [KEY_MAX];
   logic [6:0] rdIdx_q;
   logic [6:0] idx1;
   logic [6:0] idx2;
   logic [6:0] idx3;
   logic [6:0] idx4;

   // Key bytes arrive one at a time; the buffer needs no reset because it
   // is always fully rewritten up to key_len before it is read.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         keyBuf_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Four chained single-step wraps give the byte indices of the current
   // word; the fourth one is where the next word starts.
   always_comb begin
      idx1   = wrapInc(rdIdx_q, key_len_i);
      idx2   = wrapInc(idx1, key_len_i);
      idx3   = wrapInc(idx2, key_len_i);
      idx4   = wrapInc(idx3, key_len_i);
      word_o = {keyBuf_q[rdIdx_q], keyBuf_q[idx1], keyBuf_q[idx2], keyBuf_q[idx3]};
   end

   // Read pointer sits at zero until emission starts, then steps a word.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rdIdx_q <= 7'd0;
      end else if (rd_clear_i) begin
         rdIdx_q <= 7'd0;
      end else if (rd_adv_i) begin
         rdIdx_q <= idx4;
      end
   end

endmodule

// File: rtl/bcrypt_loader.sv
// Parses a byte-serial configuration frame (header, cost, key, salt and an
// optional checksum) and loads the bcrypt core's key and salt memories.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte).
module bcrypt_loader
   import bcrypt_pkg::*;
(
   input  logic        clk,
   input  logic        rst_l,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        key_we,
   output logic [4:0]  key_addr,
   output logic [31:0] key_wdata,
   output logic        salt_we,
   output logic [1:0]  salt_addr,
   output logic [31:0] salt_wdata,
   output logic [63:0] cost,
   output logic        start,
   input  logic        core_done,
   output logic        err
);

   state_e      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [6:0]  keyLen_q, keyLen_d;
   logic [23:0] saltWord_q, saltWord_d;
   logic [63:0] cost_q, cost_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif
   logic        fire;
   logic        keyWr;
   logic        rdClear;
   logic        rdAdv;
   logic [31:0] keyWord;

   assign fire = rx_valid && rx_ready;
   assign cost = cost_q;

   key_cycler u_key_cycler (
      .clk        (clk),
      .rst_l      (rst_l),
      .wr_en_i    (keyWr),
      .wr_idx_i   (cnt_q),
      .wr_data_i  (rx_data),
      .key_len_i  (keyLen_q),
      .rd_clear_i (rdClear),
      .rd_adv_i   (rdAdv),
      .word_o     (keyWord)
   );

   // State register and frame bookkeeping.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         cnt_q      <= 7'd0;
         keyLen_q   <= 7'd0;
         saltWord_q <= 24'd0;
         cost_q     <= 64'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         keyLen_q   <= keyLen_d;
         saltWord_q <= saltWord_d;
         cost_q     <= cost_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Frame parser: next state plus all write-port outputs, which are zero
   // outside the state that owns them so reset silences them at once.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      keyLen_d   = keyLen_q;
      saltWord_d = saltWord_q;
      cost_d     = cost_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      rx_ready   = 1'b0;
      key_we     = 1'b0;
      key_addr   = 5'd0;
      key_wdata  = 32'd0;
      salt_we    = 1'b0;
      salt_addr  = 2'd0;
      salt_wdata = 32'd0;
      start      = 1'b0;
      err        = 1'b0;
      keyWr      = 1'b0;
      rdClear    = 1'b1;
      rdAdv      = 1'b0;
      case (state_q)
         IDLE: begin
            rx_ready = 1'b1;
            if (fire && rx_data == HDR_BYTE) begin
               state_d = COST;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end
         COST: begin
            rx_ready = 1'b1;
            if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (rx_data < 8'(COST_MIN) || rx_data > 8'(COST_MAX)) begin
                  state_d = ERR;
               end else begin
                  cost_d  = 64'd1 << rx_data[4:0];
                  state_d = KLEN;
               end
            end
         end
         KLEN: begin
            rx_ready = 1'b1;
            if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (rx_data == 8'd0 || rx_data > 8'(KEY_MAX)) begin
                  state_d = ERR;
               end else begin
                  keyLen_d = rx_data[6:0];
                  cnt_d    = 7'd0;
                  state_d  = KEY;
               end
            end
         end
         KEY: begin
            rx_ready = 1'b1;
            if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               keyWr = 1'b1;
               if (cnt_q == keyLen_q - 7'd1) begin
                  cnt_d   = 7'd0;
                  state_d = SALT;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         SALT: begin
            rx_ready = 1'b1;
            if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               saltWord_d = {saltWord_q[15:0], rx_data};
               if (cnt_q[1:0] == 2'd3) begin
                  salt_we    = 1'b1;
                  salt_addr  = cnt_q[3:2];
                  salt_wdata = {saltWord_q, rx_data};
               end
               if (cnt_q == 7'(SALT_BYTES - 1)) begin
                  cnt_d   = 7'd0;
`ifdef LOADER_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = EMIT;
`endif
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            rx_ready = 1'b1;
            if (fire) begin
               state_d = (rx_data == csum_q) ? EMIT : ERR;
            end
         end
`endif
         EMIT: begin
            rdClear   = 1'b0;
            rdAdv     = 1'b1;
            key_we    = 1'b1;
            key_addr  = cnt_q[4:0];
            key_wdata = keyWord;
            if (cnt_q == 7'(KEY_WORDS - 1)) begin
               cnt_d   = 7'd0;
               state_d = ARMED;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         ARMED: begin
            start = 1'b1;
            if (core_done) begin
               state_d = IDLE;
            end
         end
         ERR: begin
            err     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bcrypt_loader.sv
// Scoreboard bench for bcrypt_loader: frames are built by a reference model
// that queues the expected key/salt writes and error pulses; a negedge
// monitor pops and compares whenever the loader writes or flags an error.
module tb_bcrypt_loader;

   logic        clk = 1'b0;
   logic        rst_l;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        key_we;
   logic [4:0]  key_addr;
   logic [31:0] key_wdata;
   logic        salt_we;
   logic [1:0]  salt_addr;
   logic [31:0] salt_wdata;
   logic [63:0] cost;
   logic        start;
   logic        core_done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [36:0]  keyQ[$];
   logic [33:0]  saltQ[$];
   int           pendingErr = 0;
   logic [63:0]  curCost = 64'd0;
   byte unsigned keyBuf[72];
   byte unsigned saltBuf[16];
   byte unsigned frame[$];

   bcrypt_loader dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .key_we     (key_we),
      .key_addr   (key_addr),
      .key_wdata  (key_wdata),
      .salt_we    (salt_we),
      .salt_addr  (salt_addr),
      .salt_wdata (salt_wdata),
      .cost       (cost),
      .start      (start),
      .core_done  (core_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: compare every write and error pulse against the scoreboard.
   logic prevKey17 = 1'b0;
   logic prevStart = 1'b0;
   logic prevErr   = 1'b0;
   always @(negedge clk) begin
      logic [36:0] ke;
      logic [33:0] se;
      if (rst_l) begin
         if (key_we) begin
            if (keyQ.size() == 0) checkOutput("spurious key_we", 1, 0);
            else begin
               ke = keyQ.pop_front();
               checkOutput("key_addr", key_addr, ke[36:32]);
               checkOutput("key_wdata", key_wdata, ke[31:0]);
            end
         end
         if (salt_we) begin
            if (saltQ.size() == 0) checkOutput("spurious salt_we", 1, 0);
            else begin
               se = saltQ.pop_front();
               checkOutput("salt_addr", salt_addr, se[33:32]);
               checkOutput("salt_wdata", salt_wdata, se[31:0]);
            end
         end
         if (err) begin
            if (pendingErr == 0) checkOutput("spurious err", 1, 0);
            else pendingErr--;
            if (prevErr) checkOutput("err longer than one cycle", 1, 0);
         end
         if (start && !prevStart) checkOutput("start one cycle after key_addr 17", prevKey17, 1);
         prevKey17 = key_we && (key_addr == 5'd17);
         prevStart = start;
         prevErr   = err;
      end else begin
         prevKey17 = 1'b0;
         prevStart = start;
         prevErr   = 1'b0;
      end
   end

   // Reference model: frame layout and the expected writes from the rules.
   task automatic makeFrame(input int c, input int klen, input bit corrupt, output bit ok);
      logic [31:0] word;
      logic [1:0]  kk;
      logic [4:0]  ww;
      byte unsigned x;
      frame.delete();
      frame.push_back(8'hA5);
      frame.push_back(8'(c));
      frame.push_back(8'(klen));
      ok = 1'b0;
      if (c < 4 || c > 31) begin
         pendingErr++;
         return;
      end
      curCost = 64'd1 << c;
      if (klen == 0 || klen > 72) begin
         pendingErr++;
         return;
      end
      for (int i = 0; i < klen; i++) frame.push_back(keyBuf[i]);
      for (int i = 0; i < 16; i++) frame.push_back(saltBuf[i]);
      for (int k = 0; k < 4; k++) begin
         kk = k[1:0];
         saltQ.push_back({kk, saltBuf[4*k], saltBuf[4*k+1], saltBuf[4*k+2], saltBuf[4*k+3]});
      end
`ifdef LOADER_CHECKSUM_EN
      x = 8'd0;
      for (int i = 1; i < frame.size(); i++) x = x ^ frame[i];
      if (corrupt) begin
         frame.push_back(x ^ 8'h3C);
         pendingErr++;
         return;
      end
      frame.push_back(x);
`else
      x = 8'd0;
      if (corrupt) $display("[TB] checksum not configured, corruption request ignored %0h", x);
`endif
      for (int w = 0; w < 18; w++) begin
         word = 32'd0;
         for (int b = 0; b < 4; b++) word = {word[23:0], keyBuf[(4*w + b) % klen]};
         ww = w[4:0];
         keyQ.push_back({ww, word});
      end
      ok = 1'b1;
   endtask

   task automatic randomFill();
      for (int i = 0; i < 72; i++) keyBuf[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) saltBuf[i] = 8'($urandom);
   endtask

   task automatic sendByte(input logic [7:0] b);
      int tmo;
      @(negedge clk);
      rx_data   = b;
      rx_valid  = 1'b1;
      core_done = ($urandom_range(0, 3) == 0);
      tmo = 0;
      while (!rx_ready && tmo < 50) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 50) checkOutput("rx_ready timeout", 0, 1);
      @(posedge clk);
      #1;
      rx_valid  = 1'b0;
      core_done = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
   endtask

   task automatic applyStimulus(input int skip);
      for (int i = skip; i < frame.size(); i++) sendByte(frame[i]);
   endtask

   // After a good frame: start, cost, back-pressure in ARMED, release.
   task automatic finishArmed(input bit holdA5);
      int tmo;
      tmo = 0;
      while (!start && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      checkOutput("start rises", start, 1);
      checkOutput("cost", cost, curCost);
      checkOutput("key writes drained", keyQ.size(), 0);
      checkOutput("salt writes drained", saltQ.size(), 0);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rx_ready in ARMED", rx_ready, 0);
         checkOutput("start held in ARMED", start, 1);
      end
      core_done = 1'b1;
      rx_valid  = holdA5;
      @(negedge clk);
      core_done = 1'b0;
      checkOutput("start falls after core_done", start, 0);
      if (holdA5) begin
         checkOutput("rx_ready back in IDLE", rx_ready, 1);
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic checkErrFrame();
      repeat (3) @(negedge clk);
      checkOutput("err pulses seen", pendingErr, 0);
      checkOutput("rx_ready after err", rx_ready, 1);
      checkOutput("cost after err", cost, curCost);
      checkOutput("no key writes on err", keyQ.size(), 0);
      checkOutput("salt writes on err", saltQ.size(), 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit ok;
      bit sawStart;
      int c, klen, tmo;
      rst_l     = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'd0;
      core_done = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset rx_ready", rx_ready, 1);
      checkOutput("reset start", start, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset key_we", key_we, 0);
      checkOutput("reset salt_we", salt_we, 0);
      checkOutput("reset cost", cost, 0);
      checkOutput("reset key_addr", key_addr, 0);
      checkOutput("reset salt_wdata", salt_wdata, 0);
      rst_l = 1'b1;

      // Directed frame: "abc" key, salt 00..0F, cost_log2 4.
      keyBuf[0] = 8'h61; keyBuf[1] = 8'h62; keyBuf[2] = 8'h63;
      for (int i = 0; i < 16; i++) saltBuf[i] = 8'(i);
      sendByte(8'h11);
      makeFrame(4, 3, 1'b0, ok);
      applyStimulus(0);
      finishArmed(1'b1);

      // Header already accepted while leaving ARMED; bad cost byte 03.
      pendingErr++;
      sendByte(8'h03);
      checkErrFrame();

      // key_len 73 rejected, followed by a normal load.
      randomFill();
      makeFrame(5, 73, 1'b0, ok);
      applyStimulus(0);
      checkErrFrame();
      makeFrame(6, 20, 1'b0, ok);
      applyStimulus(0);
      finishArmed(1'b0);

`ifdef LOADER_CHECKSUM_EN
      randomFill();
      makeFrame(9, 11, 1'b1, ok);
      applyStimulus(0);
      checkErrFrame();
      makeFrame(9, 11, 1'b0, ok);
      applyStimulus(0);
      finishArmed(1'b0);
`endif

      // Randomized frames, including out-of-range cost and key_len.
      for (int n = 0; n < 10; n++) begin
         randomFill();
         c    = (n == 0) ? 31 : $urandom_range(2, 33);
         klen = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 80)
              : ((n == 1) ? 72 : ((n == 2) ? 1 : $urandom_range(1, 72)));
         makeFrame(c, klen, 1'b0, ok);
         applyStimulus(0);
         if (ok) finishArmed(1'b0);
         else    checkErrFrame();
      end

      // Reset in the middle of key emission.
      randomFill();
      makeFrame(7, 9, 1'b0, ok);
      while (keyQ.size() > 8) void'(keyQ.pop_back());
      applyStimulus(0);
      tmo = 0;
      do begin
         @(negedge clk);
         tmo++;
      end while (!(key_we && key_addr == 5'd7) && tmo < 100);
      checkOutput("reached EMIT word 7", (tmo < 100), 1);
      #1 rst_l = 1'b0;
      #1;
      curCost = 64'd0;
      checkOutput("key_we under reset", key_we, 0);
      checkOutput("key_addr under reset", key_addr, 0);
      checkOutput("start under reset", start, 0);
      checkOutput("cost under reset", cost, 0);
      checkOutput("rx_ready under reset", rx_ready, 1);
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      sawStart = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (start) sawStart = 1'b1;
      end
      checkOutput("start after aborted frame", sawStart, 0);
      checkOutput("key writes before reset", keyQ.size(), 0);
      checkOutput("rx_ready after reset", rx_ready, 1);
      checkOutput("final err count", pendingErr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcrypt_loader.md
BCRYPT_LOADER -- requirements
Module: bcrypt_loader

Interface
REQ-001 The block SHALL use one clock, clk, and one asynchronous active-low reset, rst_l; the state registers SHALL sample on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst_l  in  1  asynchronous active-low reset.
REQ-004 rx_data  in  8  received frame byte from the UART receiver.
REQ-005 rx_valid  in  1  rx_data holds a valid byte.
REQ-006 rx_ready  out  1  the loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-007 key_we, key_addr, key_wdata  out  1/5/32  write port for the 18-word expanded key.
REQ-008 salt_we, salt_addr, salt_wdata  out  1/2/32  write port for the 4-word salt.
REQ-009 cost  out  64  iteration count, equal to 1 << cost_log2.
REQ-010 start  out  1  level signal to state_fsm; it indicates that the core's inputs are loaded.
REQ-011 core_done  in  1  one-cycle pulse from the core when the hash is complete.
REQ-012 err  out  1  one-cycle pulse when a frame is rejected.

Function
REQ-013 The frame SHALL be: header 8'hA5, cost_log2, key_len, key_len key bytes, 16 salt bytes, and, when configured, a checksum byte.
REQ-014 The states SHALL be IDLE, COST, KLEN, KEY, SALT, CSUM, EMIT, ARMED and ERR.
REQ-015 rx_ready SHALL be 1 only in IDLE, COST, KLEN, KEY, SALT and CSUM.
REQ-016 IDLE: an accepted byte equal to 8'hA5 SHALL move the block to COST; any other byte SHALL be discarded silently.
REQ-017 COST: the block SHALL accept the byte and go to ERR if the value is outside 4..31; otherwise it SHALL set cost to 1<<value in the same cycle and go to KLEN.
REQ-018 KLEN: a value of 0 or greater than 72 SHALL send the block to ERR; otherwise it SHALL latch key_len and go to KEY.
REQ-019 KEY: the block SHALL store byte i in an internal 72-byte buffer and go to SALT after byte key_len-1.
REQ-020 SALT: the block SHALL pack bytes big-endian, first byte in bits [31:24]; on every 4th accepted byte, salt_we SHALL pulse for one cycle with salt_addr = 0..3. After the 16th byte the block SHALL go to CSUM if configured, otherwise to EMIT.
REQ-021 EMIT: for 18 consecutive cycles key_we SHALL be 1 with key_addr = 0..17; word w SHALL contain expanded bytes 4w..4w+3, big-endian, where expanded byte j = key[j mod key_len].
REQ-022 The byte index SHALL wrap to 0 on reaching key_len and SHALL NOT use a divider.
REQ-023 ARMED SHALL be entered in the cycle after key_addr 17; start SHALL be 1 for as long as the block is in ARMED.
REQ-024 core_done in ARMED SHALL return the block to IDLE, with start = 0 in the next cycle; core_done in any other state SHALL be ignored.
REQ-025 ERR SHALL last one cycle, pulse err, and then return to IDLE; partially written salt words SHALL NOT be cleared.
REQ-026 While rx_ready is 0, rx_valid SHALL be ignored and no byte SHALL be consumed.
REQ-027 cost SHALL hold its value until the next accepted valid cost byte.

Reset
REQ-028 Asserting rst_l low SHALL immediately force the state to IDLE and drive rx_ready = 1, start = 0, err = 0, key_we = 0, salt_we = 0, cost = 0, and all addresses and data to 0.
REQ-029 Reset in any state, including mid-EMIT or ARMED, SHALL abandon the frame; no further writes SHALL occur.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, CSUM SHALL accept one byte and compare it with the XOR of all preceding frame bytes from cost_log2 onward. A match SHALL go to EMIT; a mismatch SHALL go to ERR with no key writes.
REQ-031 Without LOADER_CHECKSUM_EN, the CSUM state and the XOR accumulator SHALL not exist, and SALT SHALL go directly to EMIT.

Structure
REQ-032 bcrypt_pkg SHALL hold the state enum, HDR_BYTE = 8'hA5, KEY_MAX = 72, KEY_WORDS = 18, SALT_BYTES = 16, COST_MIN = 4 and COST_MAX = 31.
REQ-033 A sub-module key_cycler SHALL hold the 72-byte buffer and the wrapping read index, and SHALL supply one 32-bit word per cycle to EMIT.

Verification
REQ-034 Frame A5,04,03,"abc",salt 00..0F -> cost = 16; salt words 00010203, 04050607, 08090A0B, 0C0D0E0F; key words 0..17 all cycle "abca","bcab","cabc"; start rises 1 cycle after key_addr 17.
REQ-035 Cost byte 03 -> err pulse, state IDLE, cost unchanged, no key_we.
REQ-036 key_len 73 -> err pulse, state IDLE; then a valid frame -> normal load.
REQ-037 rx_valid held high in ARMED -> rx_ready = 0 and no byte consumed; core_done pulse -> start falls next cycle and the next A5 is accepted.
REQ-038 rst_l pulsed at EMIT word 7 -> key_we = 0 immediately, start never rises, state IDLE.
REQ-039 With LOADER_CHECKSUM_EN defined, a corrupted checksum -> err pulse and no key writes; the correct checksum -> normal load.
